// File: rtl/if_fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// The ID stage and the hazard unit reuse these as well.
// Contents:
//   fetch_state_e - fetch FSM state encodings (BOOT, RUN, BUBBLE)
//   DEF_*         - default widths, reset PC, PC increment and NOP encoding
//   sat_inc16     - saturating 16-bit increment used by event counters
package if_fetch_pc_unit_pkg;

  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_INSTR_W  = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_PC_INC   = 4;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

  // Encoding 2'b11 is unused. The FSM recovers from it to ST_RUN.
  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_BUBBLE = 2'b10
  } fetch_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/if_fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   load       - capture pc_in / pc_next_in / instr_in and mark the entry valid
//   flush      - replace the instruction with NOP_WORD and clear valid;
//                the PC fields keep their previous values
//   pc_in, pc_next_in, instr_in - next IF/ID contents
//   pc, pc_next, instr, valid   - registered IF/ID contents
// When neither load nor flush is asserted, every field holds.
// flush takes precedence over load.
module if_fetch_pc_unit_if_id_reg #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [ADDR_W-1:0]  pc_next_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_next,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      pc_next <= '0;
      instr   <= NOP_WORD;
      valid   <= 1'b0;
    end else if (flush) begin
      instr   <= NOP_WORD;
      valid   <= 1'b0;
    end else if (load) begin
      pc      <= pc_in;
      pc_next <= pc_next_in;
      instr   <= instr_in;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_pc_unit.sv
// Instruction-fetch stage.
// This block owns the PC, drives the instruction-memory address and
// feeds the IF/ID register.
// Ports:
//   clk, rst         - clock and asynchronous active-high reset
//   redirect         - take redirect_target this edge (beats stall)
//   redirect_target  - resolved branch/jump target
//   stall            - hold PC, IF/ID and FSM state
//   imem_addr        - instruction address (equals pc, combinational)
//   imem_rdata       - instruction word for imem_addr, same cycle
//   if_id_pc, if_id_pc_next, if_id_instr, if_id_valid - IF/ID contents
//   flush_o          - one-cycle pulse after an accepted redirect
//   redirect_cnt     - saturating count of accepted redirects
// A redirect loads the target into the PC and places a bubble in IF/ID.
// The target instruction therefore reaches IF/ID on the next unstalled edge.
module if_fetch_pc_unit
  import if_fetch_pc_unit_pkg::*;
#(
  parameter int                 ADDR_W   = DEF_ADDR_W,
  parameter int                 INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = DEF_RESET_PC,
  parameter int                 PC_INC   = DEF_PC_INC,
  parameter logic [INSTR_W-1:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               stall,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc_next,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic               flush_o,
  output logic [15:0]        redirect_cnt
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
  logic              ld, fl, take_redirect;

  // The sum wraps modulo 2^ADDR_W.
  assign pc_inc    = pc + ADDR_W'(PC_INC);
  assign imem_addr = pc;

  // BOOT, RUN and BUBBLE share the same edge rules and differ only in
  // where the FSM comes from.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    ld            = 1'b0;
    fl            = 1'b0;
    take_redirect = 1'b0;
    case (state)
      ST_BOOT, ST_RUN, ST_BUBBLE: begin
        if (redirect) begin
          take_redirect = 1'b1;
          pc_nxt        = redirect_target;
          fl            = 1'b1;
          state_nxt     = ST_BUBBLE;
        end else if (!stall) begin
          ld        = 1'b1;
          pc_nxt    = pc_inc;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        // An unused encoding recovers to RUN with IF/ID invalidated.
        // Any redirect presented this edge is dropped.
        fl        = 1'b1;
        state_nxt = ST_RUN;
      end
    endcase
  end

  // ---- PC / FSM / redirect bookkeeping registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_BOOT;
      pc           <= RESET_PC;
      flush_o      <= 1'b0;
      redirect_cnt <= 16'd0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      flush_o <= take_redirect;
      if (take_redirect) redirect_cnt <= sat_inc16(redirect_cnt);
    end
  end

  // ---- IF/ID boundary ----
  if_fetch_pc_unit_if_id_reg #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (ld),
    .flush      (fl),
    .pc_in      (pc),
    .pc_next_in (pc_inc),
    .instr_in   (imem_rdata),
    .pc         (if_id_pc),
    .pc_next    (if_id_pc_next),
    .instr      (if_id_instr),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_if_fetch_pc_unit.sv
module tb_if_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_next;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        flush_o;
  logic [15:0] redirect_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ifpcn;
    logic [31:0] instr;
    logic        valid;
    logic        flush;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_ifpcn, m_instr;
  logic        m_valid, m_flush;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_fetch_pc_unit dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .stall           (stall),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .if_id_pc        (if_id_pc),
    .if_id_pc_next   (if_id_pc_next),
    .if_id_instr     (if_id_instr),
    .if_id_valid     (if_id_valid),
    .flush_o         (flush_o),
    .redirect_cnt    (redirect_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifpcn = 32'h0; m_instr = 32'h0;
    m_valid = 1'b0; m_flush = 1'b0; m_cnt = 16'h0;
  endtask

  task automatic model_edge(input logic r, input logic [31:0] t, input logic s);
    if (r) begin
      m_pc    = t;
      m_instr = 32'h0;
      m_valid = 1'b0;
      m_flush = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (s) begin
      m_flush = 1'b0;
    end else begin
      m_ifpc  = m_pc;
      m_ifpcn = m_pc + 32'd4;
      m_instr = mem_word(m_pc);
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_flush = 1'b0;
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, "_addr"},  imem_addr,              e.pc);
    chk({tag, "_pc"},    if_id_pc,               e.ifpc);
    chk({tag, "_pcn"},   if_id_pc_next,          e.ifpcn);
    chk({tag, "_instr"}, if_id_instr,            e.instr);
    chk({tag, "_valid"}, {31'd0, if_id_valid},   {31'd0, e.valid});
    chk({tag, "_flush"}, {31'd0, flush_o},       {31'd0, e.flush});
    chk({tag, "_cnt"},   {16'd0, redirect_cnt},  {16'd0, e.cnt});
  endtask

  // Drive one edge, push the model's prediction and compare after the edge.
  task automatic step(input string tag, input logic r, input logic [31:0] t, input logic s);
    exp_t e;
    redirect = r; redirect_target = t; stall = s;
    model_edge(r, t, s);
    e = '{m_pc, m_ifpc, m_ifpcn, m_instr, m_valid, m_flush, m_cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      cmp_all(tag, e);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; redirect = 1'b0; redirect_target = 32'h0; stall = 1'b0;
    model_reset();
    #12;
    e = '{m_pc, m_ifpc, m_ifpcn, m_instr, m_valid, m_flush, m_cnt};
    cmp_all("reset", e);
    rst = 1'b0;

    step("boot", 1'b0, 32'h0, 1'b0);
    step("seq1", 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 32'h0, 1'b1);
    step("unstall", 1'b0, 32'h0, 1'b0);

    step("redir100", 1'b1, 32'h100, 1'b0);
    step("tgt100", 1'b0, 32'h0, 1'b0);
    step("seq104", 1'b0, 32'h0, 1'b0);

    step("redir_stall200", 1'b1, 32'h200, 1'b1);
    step("b2b300", 1'b1, 32'h300, 1'b0);
    step("bubble_stall", 1'b0, 32'h0, 1'b1);
    step("tgt300", 1'b0, 32'h0, 1'b0);

    step("redir_unaligned", 1'b1, 32'h0000_0103, 1'b0);
    step("tgt103", 1'b0, 32'h0, 1'b0);

    step("redir_top", 1'b1, 32'hFFFF_FFFC, 1'b0);
    step("wrap", 1'b0, 32'h0, 1'b0);
    step("after_wrap", 1'b0, 32'h0, 1'b0);

    // Saturation: drive many redirects and check only at the end.
    for (int i = 0; i < 65536; i++) begin
      redirect = 1'b1; redirect_target = 32'(i) << 2; stall = 1'b0;
      model_edge(1'b1, 32'(i) << 2, 1'b0);
      @(posedge clk);
    end
    #1;
    step("sat", 1'b1, 32'h400, 1'b0);
    step("sat_tgt", 1'b0, 32'h0, 1'b0);

    // Asynchronous reset while stalled.
    step("pre_rst_stall", 1'b0, 32'h0, 1'b1);
    step("pre_rst_stall2", 1'b0, 32'h0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    e = '{m_pc, m_ifpc, m_ifpcn, m_instr, m_valid, m_flush, m_cnt};
    cmp_all("async_rst", e);
    #3;
    rst = 1'b0;
    stall = 1'b0; redirect = 1'b0;
    step("reboot", 1'b0, 32'h0, 1'b0);
    step("reboot_seq", 1'b0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
